// File: rtl/accum_seq_pkg.sv
// ============================================================================
// Module      : accum_seq_pkg
// Description : Shared types and parameter-legality helpers for the
//               accumulator sequencer (state encoding, counter widths,
//               elaboration-time parameter checks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_seq_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RD   = 3'd2,
    ST_LD   = 3'd3,
    ST_TR   = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Bits needed to count n distinct values (never less than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit group_len_ok(input int group_len);
    return group_len >= 2;
  endfunction

  function automatic bit rd_lat_ok(input int rd_lat);
    return rd_lat >= 1;
  endfunction

  // All groups must fit in the address space without wrapping.
  function automatic bit capacity_ok(input int addr_w, input int group_len,
                                     input int num_groups);
    return (num_groups >= 1) && ((num_groups * group_len) <= (1 << addr_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/accum_seq_addr_gen.sv
// ============================================================================
// Module      : accum_seq_addr_gen
// Description : Address register plus operand and group counters for the
//               accumulator sequencer.
// Ports       : clk, rst_n         - clock, async active-low reset
//               i_clr              - synchronous clear of address and counters
//               i_op_step          - advance to next operand / result slot
//               i_grp_step         - leave result slot: next base or back to 0
//               o_address          - memory address
//               o_last_operand     - current operand is the group's last
//               o_last_group       - current group is the run's last
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_seq_addr_gen
  import accum_seq_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int GROUP_LEN  = 8,
  parameter int NUM_GROUPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_op_step,
  input  logic              i_grp_step,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_last_operand,
  output logic              o_last_group
);

  localparam int OP_W  = cnt_w(GROUP_LEN - 1);
  localparam int GRP_W = cnt_w(NUM_GROUPS);
  localparam logic [OP_W-1:0]  LAST_OP  = OP_W'(GROUP_LEN - 2);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [OP_W-1:0]   r_op_cnt;
  logic [GRP_W-1:0]  r_grp_cnt;
  logic              w_last_op;
  logic              w_last_grp;

  assign w_last_op  = (r_op_cnt == LAST_OP);
  assign w_last_grp = (r_grp_cnt == LAST_GRP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_op_cnt  <= '0;
      r_grp_cnt <= '0;
    end else if (i_clr) begin
      r_addr    <= '0;
      r_op_cnt  <= '0;
      r_grp_cnt <= '0;
    end else if (i_op_step) begin
      // After the last operand the address lands on the result slot.
      r_addr   <= r_addr + ADDR_W'(1);
      r_op_cnt <= w_last_op ? '0 : r_op_cnt + OP_W'(1);
    end else if (i_grp_step) begin
      // Final result slot may be 2**ADDR_W-1; return to 0 explicitly
      // rather than relying on wrap-around.
      if (w_last_grp) begin
        r_addr    <= '0;
        r_grp_cnt <= '0;
      end else begin
        r_addr    <= r_addr + ADDR_W'(1);
        r_grp_cnt <= r_grp_cnt + GRP_W'(1);
      end
    end
  end

  assign o_address      = r_addr;
  assign o_last_operand = w_last_op;
  assign o_last_group   = w_last_grp;

endmodule

`default_nettype wire

// File: rtl/accum_sequencer.sv
// ============================================================================
// Module      : accum_sequencer
// Description : Control sequencer for a RAM-plus-accumulator datapath. Walks
//               NUM_GROUPS groups of GROUP_LEN words, accumulates the first
//               GROUP_LEN-1 words of each group and writes the sum into the
//               group's last word. Start/busy handshake, continuous mode,
//               abort and configurable read latency.
// Ports       : clk, rst_n   - clock, async active-low reset
//               i_start      - run request (sampled in IDLE only)
//               i_cont       - continuous mode, checked at DONE
//               i_abort      - synchronous abort to IDLE
//               o_address    - memory address
//               o_rden       - memory read enable
//               o_wren       - memory write enable (data = accumulator)
//               o_load       - accumulator operand load strobe
//               o_clear      - accumulator clear, active-low
//               o_transf     - accumulator transfer/add strobe
//               o_ready      - one-cycle run-complete pulse
//               o_busy       - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int GROUP_LEN  = 8,
  parameter int NUM_GROUPS = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_rden,
  output logic              o_wren,
  output logic              o_load,
  output logic              o_clear,
  output logic              o_transf,
  output logic              o_ready,
  output logic              o_busy
);

  // Parameter legality, checked at elaboration.
  if (!group_len_ok(GROUP_LEN)) begin : g_chk_group_len
    $error("accum_sequencer: GROUP_LEN must be >= 2");
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_chk_rd_lat
    $error("accum_sequencer: RD_LAT must be >= 1");
  end
  if (!capacity_ok(ADDR_W, GROUP_LEN, NUM_GROUPS)) begin : g_chk_capacity
    $error("accum_sequencer: NUM_GROUPS*GROUP_LEN exceeds address space");
  end

  localparam int LAT_W = cnt_w(RD_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [LAT_W-1:0] r_lat;
  logic             w_lat_done;
  logic             w_last_operand;
  logic             w_last_group;
  logic             w_op_step;
  logic             w_grp_step;

  logic r_rden, r_wren, r_load, r_clear, r_transf, r_ready, r_busy;

  // ---------------------------------------------------------------------
  // Address and counters
  // ---------------------------------------------------------------------
  assign w_op_step  = (r_state == ST_TR) && !i_abort;
  assign w_grp_step = (r_state == ST_WR) && !i_abort;

  accum_seq_addr_gen #(
    .ADDR_W     (ADDR_W),
    .GROUP_LEN  (GROUP_LEN),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (i_abort),
    .i_op_step      (w_op_step),
    .i_grp_step     (w_grp_step),
    .o_address      (o_address),
    .o_last_operand (w_last_operand),
    .o_last_group   (w_last_group)
  );

  // ---------------------------------------------------------------------
  // Read latency counter: counts RD cycles, restarts outside RD.
  // ---------------------------------------------------------------------
  assign w_lat_done = (r_lat == LAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat <= '0;
    end else if ((r_state == ST_RD) && !w_lat_done && !i_abort) begin
      r_lat <= r_lat + LAT_W'(1);
    end else begin
      r_lat <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_CLR;
      ST_CLR:  w_next = ST_RD;
      ST_RD:   if (w_lat_done) w_next = ST_LD;
      ST_LD:   w_next = ST_TR;
      ST_TR:   w_next = w_last_operand ? ST_WR : ST_RD;
      ST_WR:   w_next = w_last_group ? ST_DONE : ST_CLR;
      ST_DONE: w_next = i_cont ? ST_CLR : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a start in IDLE.
    if (i_abort) begin
      w_next = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers: decoded from the next state so each strobe is a
  // flop that lines up exactly with the state it belongs to.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rden   <= 1'b0;
      r_wren   <= 1'b0;
      r_load   <= 1'b0;
      r_clear  <= 1'b0;
      r_transf <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rden   <= (w_next == ST_RD) || (w_next == ST_LD);
      r_wren   <= (w_next == ST_WR);
      r_load   <= (w_next == ST_LD);
      r_clear  <= !((w_next == ST_IDLE) || (w_next == ST_CLR));
      r_transf <= (w_next == ST_TR);
      r_ready  <= (w_next == ST_DONE);
      r_busy   <= (w_next != ST_IDLE);
    end
  end

  assign o_rden   = r_rden;
  assign o_wren   = r_wren;
  assign o_load   = r_load;
  assign o_clear  = r_clear;
  assign o_transf = r_transf;
  assign o_ready  = r_ready;
  assign o_busy   = r_busy;

endmodule

`default_nettype wire
